// File: rtl/spi_slave.sv
// SPI mode-0 slave running entirely in the sysclk domain.
// sck, cs_n and mosi are oversampled through synchronizers, and all edges are detected from those samples.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [7:0]  data_in,
  output logic        load_ack,
  output logic [7:0]  data_out,
  output logic        new_data,
  output logic        busy,
  output logic [15:0] byte_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_d, cs_d;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  logic       start, shift, advance, abort;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;
  logic [2:0] bit_cnt;

  // The synchronizers reset to bus-idle levels, so reset release cannot fake an edge.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop take the old value of the previous flop, which forms a real chain.
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A deselect takes priority over any sck edge seen in the same cycle.
  always_comb begin
    // NOTE: every output gets a default here first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    start   = 1'b0;
    shift   = 1'b0;
    advance = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (sck_rise) begin
          shift = 1'b1;
        end else if (sck_fall) begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      load_ack   <= 1'b0;
      data_out   <= 8'h00;
      new_data   <= 1'b0;
      busy       <= 1'b0;
      byte_count <= 16'h0000;
      rx_sr      <= 7'h00;
      tx_sr      <= 8'h00;
      bit_cnt    <= 3'd0;
    end else begin
      load_ack <= 1'b0;
      new_data <= 1'b0;
      busy     <= (state_d == ACTIVE);
      if (start) begin
        tx_sr      <= data_in;
        load_ack   <= 1'b1;
        bit_cnt    <= 3'd0;
        byte_count <= 16'h0000;
        miso       <= data_in[7];
        miso_oe    <= 1'b1;
      end
      if (abort) begin
        bit_cnt <= 3'd0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end
      if (shift) begin
        rx_sr   <= {rx_sr[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          data_out <= {rx_sr, mosi_s};
          new_data <= 1'b1;
          if (byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
          tx_sr    <= data_in;
          load_ack <= 1'b1;
        end
      end
      // bit_cnt == 0 on a fall means the tx register was just reloaded, so its MSB goes out unshifted.
      if (advance) begin
        if (bit_cnt == 3'd0) begin
          miso <= tx_sr[7];
        end else begin
          miso  <= tx_sr[6];
          tx_sr <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a mode-0 master model at sysclk/8 plus a byte-level reference model.
// Directed cases cover single byte, burst, abort, idle sck and mid-byte reset; random bursts follow.
module tb_spi_slave;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        sck    = 1'b0;
  logic        cs_n   = 1'b1;
  logic        mosi   = 1'b0;
  logic        miso, miso_oe, load_ack, new_data, busy;
  logic [7:0]  data_in, data_out;
  logic [15:0] byte_count;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .data_in(data_in), .load_ack(load_ack),
    .data_out(data_out), .new_data(new_data), .busy(busy), .byte_count(byte_count)
  );

  always #5 sysclk = ~sysclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes offered to the slave (one per load), bytes the master sends, bytes it sees on miso.
  logic [7:0] tx_q[$];
  logic [7:0] mosi_q[$];
  logic [7:0] miso_got[$];
  logic [7:0] rx_got[$];
  logic [7:0] model_data_out = 8'h00;
  int         model_byte_count = 0;

  // The monitor records the received bytes and counts loads, and it presents the next queued byte on data_in.
  int   ack_cnt   = 0;
  int   width_err = 0;
  logic nd_prev   = 1'b0;
  logic ack_prev  = 1'b0;

  always @(negedge sysclk) begin
    if (new_data === 1'b1) rx_got.push_back(data_out);
    if (load_ack === 1'b1) ack_cnt++;
    if ((new_data === 1'b1 && nd_prev) || (load_ack === 1'b1 && ack_prev)) width_err++;
    nd_prev  = (new_data === 1'b1);
    ack_prev = (load_ack === 1'b1);
    data_in  = (ack_cnt < tx_q.size()) ? tx_q[ack_cnt] : 8'h00;
  end

  // Mode-0 master: mosi changes while sck is low, miso is sampled just before each rising edge.
  task automatic xfer(input int nbits, input bit raise_cs);
    logic [7:0] mi;
    mi = 8'h00;
    @(negedge sysclk);
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_q[i / 8][7 - (i % 8)];
      repeat (4) @(negedge sysclk);
      if (i == 0) begin
        check("busy_while_selected", busy, 1);
        check("miso_oe_while_selected", miso_oe, 1);
      end
      mi = {mi[6:0], miso};
      if (i % 8 == 7) miso_got.push_back(mi);
      sck = 1'b1;
      repeat (4) @(negedge sysclk);
      sck = 1'b0;
    end
    if (raise_cs) begin
      repeat (4) @(negedge sysclk);
      cs_n = 1'b1;
      repeat (8) @(negedge sysclk);
    end
  endtask

  // The caller fills mosi_q and pushes one tx byte for every load the transaction will cause.
  task automatic run_and_check(input string name, input int nfull, input int extra);
    int         nd0, ack0;
    logic [7:0] exp_last;
    nd0  = rx_got.size();
    ack0 = ack_cnt;
    miso_got.delete();
    exp_last = (nfull > 0) ? mosi_q[nfull-1] : model_data_out;
    xfer(nfull * 8 + extra, 1'b1);
    check({name, "_new_data_count"}, rx_got.size() - nd0, nfull);
    for (int k = 0; k < nfull; k++) begin
      check({name, "_rx_byte"}, (nd0 + k < rx_got.size()) ? rx_got[nd0 + k] : 8'hxx, mosi_q[k]);
      check({name, "_miso_byte"}, miso_got[k], tx_q[ack0 + k]);
    end
    check({name, "_data_out"}, data_out, exp_last);
    check({name, "_byte_count"}, byte_count, nfull);
    check({name, "_load_count"}, ack_cnt - ack0, nfull + 1);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_miso_oe_after"}, miso_oe, 0);
    check({name, "_miso_after"}, miso, 0);
    model_data_out   = exp_last;
    model_byte_count = nfull;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_miso"}, miso, 0);
    check({name, "_miso_oe"}, miso_oe, 0);
    check({name, "_load_ack"}, load_ack, 0);
    check({name, "_data_out"}, data_out, 8'h00);
    check({name, "_new_data"}, new_data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_byte_count"}, byte_count, 16'h0000);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd0, ack0, nfull, extra;

    repeat (3) @(negedge sysclk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge sysclk);

    // Single byte.
    mosi_q = '{8'h5B};
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h77);
    repeat (2) @(negedge sysclk);
    run_and_check("single", 1, 0);

    // Three-byte burst with data_in following each load.
    mosi_q = '{8'h5B, 8'h3C, 8'hFF};
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    repeat (2) @(negedge sysclk);
    run_and_check("burst", 3, 0);

    // Abort after five rising edges: data_out keeps the previous byte.
    mosi_q = '{8'hC3};
    tx_q.push_back(8'h99);
    repeat (2) @(negedge sysclk);
    run_and_check("abort", 0, 5);

    // sck activity while deselected is ignored.
    nd0  = rx_got.size();
    ack0 = ack_cnt;
    for (int i = 0; i < 16; i++) begin
      sck = ~sck;
      repeat (4) @(negedge sysclk);
    end
    repeat (4) @(negedge sysclk);
    check("idle_sck_busy", busy, 0);
    check("idle_sck_miso_oe", miso_oe, 0);
    check("idle_sck_new_data_count", rx_got.size() - nd0, 0);
    check("idle_sck_load_count", ack_cnt - ack0, 0);
    check("idle_sck_byte_count", byte_count, model_byte_count);

    // Reset after four bits of a byte, then a fresh transaction.
    mosi_q = '{8'h5B};
    tx_q.push_back(8'hE7);
    repeat (2) @(negedge sysclk);
    nd0 = rx_got.size();
    xfer(4, 1'b0);
    @(negedge sysclk);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    cs_n = 1'b1;
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (6) @(negedge sysclk);
    check("mid_reset_no_new_data", rx_got.size() - nd0, 0);
    check("mid_reset_stays_idle", busy, 0);
    model_data_out   = 8'h00;
    model_byte_count = 0;
    mosi_q = '{8'h5B};
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h0F);
    repeat (2) @(negedge sysclk);
    run_and_check("after_reset", 1, 0);

    // Random bursts, some ending with a discarded partial byte.
    for (int t = 0; t < 6; t++) begin
      nfull = $urandom_range(1, 4);
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      mosi_q.delete();
      for (int k = 0; k < nfull + 1; k++) begin
        mosi_q.push_back(8'($urandom));
        tx_q.push_back(8'($urandom));
      end
      repeat (2) @(negedge sysclk);
      run_and_check("random", nfull, extra);
    end

    check("pulse_width", width_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sck/cs_n/mosi (legal 2..3).
REQ-002 SHALL have port sysclk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port sck  input  1  SPI clock from master, asynchronous to sysclk.
REQ-005 SHALL have port cs_n  input  1  chip select from master, active-low.
REQ-006 SHALL have port mosi  input  1  serial data from master.
REQ-007 SHALL have port miso  output  1  serial data to master, MSB first.
REQ-008 SHALL have port miso_oe  output  1  high while selected; external tri-state enable.
REQ-009 SHALL have port data_in  input  8  next byte to transmit, sampled at load points.
REQ-010 SHALL have port load_ack  output  1  one-cycle pulse when data_in was captured.
REQ-011 SHALL have port data_out  output  8  last complete received byte.
REQ-012 SHALL have port new_data  output  1  one-cycle pulse, data_out updated this cycle.
REQ-013 SHALL have port busy  output  1  high while in ACTIVE state.
REQ-014 SHALL have port byte_count  output  16  complete bytes received in current transaction.

Function
REQ-015 SHALL implement SPI mode 0 (CPOL=0, CPHA=0): sample mosi on sck rise, change miso on sck fall, MSB first, 8-bit frames.
REQ-016 SHALL pass sck, cs_n, mosi through SYNC_STAGES flops, then detect edges by comparing with one extra registered copy; no logic clocked by sck.
REQ-017 SHALL support sck frequency up to sysclk/8; master SHALL allow >=4 sysclk from cs_n fall to first sck rise.
REQ-018 SHALL use a 2-state FSM: IDLE, ACTIVE.
REQ-019 IDLE->ACTIVE on synchronized cs_n falling edge: capture data_in into tx shift register, pulse load_ack, clear bit counter and byte_count, drive miso = data_in[7], miso_oe=1.
REQ-020 In ACTIVE, each synchronized sck rise SHALL shift synchronized mosi into rx register LSB and increment 3-bit bit counter (wraps 7->0).
REQ-021 On the rise that completes bit 8: data_out <= full byte, new_data pulses one cycle later than the edge detect, byte_count increments (saturates at 0xFFFF), data_in captured into tx register and load_ack pulses the same cycle.
REQ-022 Each synchronized sck fall SHALL present next tx bit on miso; the fall after a byte boundary SHALL present MSB of the newly loaded byte.
REQ-023 ACTIVE->IDLE on synchronized cs_n rise at any point: partial byte discarded, no new_data, bit counter cleared, miso_oe=0, miso=0; data_out and byte_count hold.
REQ-024 sck edges while in IDLE SHALL be ignored; cs_n rise and sck edge detected in same cycle: cs_n wins, sck edge ignored.
REQ-025 new_data and load_ack SHALL never be high longer than one cycle per event.
REQ-026 busy SHALL equal (state == ACTIVE), registered.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, miso=0, miso_oe=0, load_ack=0, data_out=0x00, new_data=0, busy=0, byte_count=0, synchronizers set to idle levels (sck=0, cs_n=1, mosi=0).
REQ-028 Reset mid-transaction SHALL abort without new_data; after release, block SHALL wait for a fresh cs_n falling edge before ACTIVE.

Verification
REQ-029 Single byte: data_in=0xA5, master sends 0x5B at sysclk/8 -> one new_data with data_out=0x5B, miso bits 1,0,1,0,0,1,0,1, byte_count=1, load_ack pulses twice (cs fall, byte end).
REQ-030 Three-byte burst: master sends 0x5B,0x3C,0xFF, data_in changed to 0x11,0x22 after each load_ack -> three new_data pulses with 0x5B,0x3C,0xFF; miso bytes 0xA5,0x11,0x22; byte_count=3.
REQ-031 Abort: cs_n raised after 5 sck rises -> no new_data, busy falls, miso_oe=0, data_out retains previous value.
REQ-032 Idle sck: sck toggles 16 times with cs_n=1 -> busy=0, miso_oe=0, no new_data, byte_count unchanged.
REQ-033 Reset mid-byte: rst_n low after 4 bits -> all outputs to REQ-027 values immediately; next full transaction of 0x5B yields data_out=0x5B, byte_count=1.
